// File: rtl/dsm_decimator_if.sv
// Stream-side port bundle of the sinc1 decimator: run control, bitstream in,
// valid/ready sample out and status. master = decimator, slave = consumer/driver.
interface dsm_decimator_if #(
    parameter int OSR_LOG2 = 7
);
    logic                en;
    logic                bit_in;
    logic                out_ready;
    logic [OSR_LOG2:0]   out_data;
    logic                out_valid;
    logic                overrun;
    logic                busy;

    modport master (
        input  en,
        input  bit_in,
        input  out_ready,
        output out_data,
        output out_valid,
        output overrun,
        output busy
    );

    modport slave (
        output en,
        output bit_in,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/dsm_decimator.sv
// First-order (sinc1) decimator: counts ones over 2^OSR_LOG2-clock windows of the DSM bitstream.
// Optional build macro DSM_DECIM_SAT_EN saturates the count at L-1 so results fit OSR_LOG2 bits.
module dsm_decimator #(
    parameter int OSR_LOG2 = 7,
    parameter int SETTLE   = 2
) (
    input  logic            clk,
    input  logic            reset,
    dsm_decimator_if.master dif
);
    localparam int CW = OSR_LOG2 + 1;

    localparam logic [OSR_LOG2-1:0] WIN_LAST    = {OSR_LOG2{1'b1}};
    localparam logic [OSR_LOG2-1:0] WIN_ZERO    = {OSR_LOG2{1'b0}};
    localparam logic [OSR_LOG2-1:0] WIN_ONE     = OSR_LOG2'(1'b1);
    localparam logic [CW-1:0]       CNT_ZERO    = {CW{1'b0}};
    localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [OSR_LOG2-1:0]    win_cnt_r, win_cnt_s;
    logic [CW-1:0]          ones_r, ones_s;
    logic [3:0]             settle_r, settle_s;
    logic [CW-1:0]          data_r, data_s;
    logic                   valid_r, valid_s;
    logic                   overrun_r, overrun_s;
    logic                   busy_r;
    logic                   close_s;
    logic [CW-1:0]          sum_s;

`ifdef DSM_DECIM_SAT_EN
    localparam logic [CW-1:0] SAT_MAX = {1'b0, {OSR_LOG2{1'b1}}};

    function automatic logic [CW-1:0] ones_add(input logic [CW-1:0] cnt, input logic b);
        if (b && (cnt != SAT_MAX)) begin
            ones_add = cnt + CW'(1'b1);
        end else begin
            ones_add = cnt;
        end
    endfunction
`else
    function automatic logic [CW-1:0] ones_add(input logic [CW-1:0] cnt, input logic b);
        ones_add = cnt + {{(CW-1){1'b0}}, b};
    endfunction
`endif

    // Next-state, window accounting and output handshake.
    always_comb begin
        state_s   = state_r;
        win_cnt_s = win_cnt_r;
        ones_s    = ones_r;
        settle_s  = settle_r;
        data_s    = data_r;
        overrun_s = overrun_r;
        close_s   = (win_cnt_r == WIN_LAST);
        sum_s     = ones_add(ones_r, dif.bit_in);

        // A transfer clears valid even in IDLE so a pending sample survives en falling.
        if (valid_r && dif.out_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (dif.en) begin
                    state_s   = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
                    win_cnt_s = WIN_ZERO;
                    ones_s    = CNT_ZERO;
                    settle_s  = 4'd0;
                    overrun_s = 1'b0;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!dif.en) begin
                    state_s = ST_IDLE;
                end else begin
                    win_cnt_s = win_cnt_r + WIN_ONE;
                    if (close_s) begin
                        ones_s   = CNT_ZERO;
                        settle_s = settle_r + 4'd1;
                        if (settle_r == SETTLE_LAST) begin
                            state_s = ST_RUN;
                        end else begin
                            state_s = ST_SETTLE;
                        end
                    end else begin
                        ones_s = sum_s;
                    end
                end
            end
            ST_RUN: begin
                if (!dif.en) begin
                    state_s = ST_IDLE;
                end else begin
                    win_cnt_s = win_cnt_r + WIN_ONE;
                    if (close_s) begin
                        ones_s = CNT_ZERO;
                        if (!valid_r || dif.out_ready) begin
                            data_s  = sum_s;
                            valid_s = 1'b1;
                        end else begin
                            overrun_s = 1'b1;
                        end
                    end else begin
                        ones_s = sum_s;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy tracks the registered state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            win_cnt_r <= WIN_ZERO;
            ones_r    <= CNT_ZERO;
            settle_r  <= 4'd0;
            data_r    <= CNT_ZERO;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            win_cnt_r <= win_cnt_s;
            ones_r    <= ones_s;
            settle_r  <= settle_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            overrun_r <= overrun_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    assign dif.out_data  = data_r;
    assign dif.out_valid = valid_r;
    assign dif.overrun   = overrun_r;
    assign dif.busy      = busy_r;
endmodule

// File: tb/tb_dsm_decimator.sv
// Scoreboard bench for dsm_decimator: default instance (L=128, SETTLE=2) and a
// small instance (L=8, SETTLE=0). Expected window counts are derived from the driven bits.
module tb_dsm_decimator;
    localparam int L      = 128;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dsm_decimator_if #(.OSR_LOG2(7)) dif ();
    dsm_decimator_if #(.OSR_LOG2(3)) dif8 ();

    dsm_decimator #(.OSR_LOG2(7), .SETTLE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif)
    );

    dsm_decimator #(.OSR_LOG2(3), .SETTLE(0)) dut8 (
        .clk   (clk),
        .reset (reset),
        .dif   (dif8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb[$];
    logic [3:0] sb8[$];
    int edge_n;
    int win_ones;
    int drop_win;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic pat(input int mode, input int pos);
        case (mode)
            0:       pat = 1'b0;
            1:       pat = 1'b1;
            2:       pat = ((pos * 37) % L) < 37;
            3:       pat = (pos % 3) == 0;
            default: pat = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] exp_count(input int ones);
`ifdef DSM_DECIM_SAT_EN
        exp_count = (ones > L - 1) ? 8'(L - 1) : 8'(ones);
`else
        exp_count = 8'(ones);
`endif
    endfunction

    // Scoreboard monitors: a transfer is valid&&ready seen between edges.
    always @(negedge clk) begin
        if (reset === 1'b0 && dif.out_valid === 1'b1 && dif.out_ready === 1'b1) begin
            if (sb.size() == 0) check_val("sb_underflow", 32'd0, 32'd1);
            else check_val("sample", 32'(dif.out_data), 32'(sb.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && dif8.out_valid === 1'b1 && dif8.out_ready === 1'b1) begin
            if (sb8.size() == 0) check_val("sb8_underflow", 32'd0, 32'd1);
            else check_val("sample8", 32'(dif8.out_data), 32'(sb8.pop_front()));
        end
    end

    task automatic run_edges(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            int pos;
            int widx;
            logic b;
            edge_n++;
            pos  = (edge_n - 1) % L;
            widx = (edge_n - 1) / L;
            b    = pat(mode, pos);
            dif.bit_in = b;
            win_ones += int'(b);
            if (pos == L - 1) begin
                if (widx >= SETTLE && widx != drop_win) sb.push_back(exp_count(win_ones));
                win_ones = 0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic enable_run();
        dif.en = 1'b1;
        @(posedge clk); #1;
        edge_n   = 0;
        win_ones = 0;
        drop_win = -1;
    endtask

    task automatic disable_run();
        dif.en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        reset = 1'b1;
        dif.en = 1'b0;  dif.bit_in = 1'b0;  dif.out_ready = 1'b1;
        dif8.en = 1'b0; dif8.bit_in = 1'b0; dif8.out_ready = 1'b1;
        edge_n = 0; win_ones = 0; drop_win = -1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(dif.out_valid), 32'd0);
        check_val("rst_data", 32'(dif.out_data), 32'd0);
        check_val("rst_overrun", 32'(dif.overrun), 32'd0);
        check_val("rst_busy", 32'(dif.busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("idle_busy", 32'(dif.busy), 32'd0);

        // 37 ones per window, consumer always ready
        enable_run();
        check_val("busy_on", 32'(dif.busy), 32'd1);
        run_edges(383, 2);
        check_val("no_valid_383", 32'(dif.out_valid), 32'd0);
        run_edges(1, 2);
        check_val("valid_384", 32'(dif.out_valid), 32'd1);
        check_val("data_384", 32'(dif.out_data), 32'h25);
        run_edges(127, 2);
        check_val("gap_511", 32'(dif.out_valid), 32'd0);
        run_edges(1, 2);
        check_val("valid_512", 32'(dif.out_valid), 32'd1);
        run_edges(128, 2);
        check_val("no_overrun", 32'(dif.overrun), 32'd0);
        disable_run();
        check_val("busy_off", 32'(dif.busy), 32'd0);
        check_val("sb_drain_37", 32'(sb.size()), 32'd0);

        // constant-one and constant-zero windows
        enable_run();
        run_edges(512, 1);
        disable_run();
        check_val("sb_drain_ones", 32'(sb.size()), 32'd0);
        enable_run();
        run_edges(512, 0);
        disable_run();
        check_val("sb_drain_zeros", 32'(sb.size()), 32'd0);

        // back-pressure through two closes: second window dropped
        dif.out_ready = 1'b0;
        enable_run();
        drop_win = 3;
        run_edges(511, 3);
        check_val("ovr_before", 32'(dif.overrun), 32'd0);
        check_val("held_valid", 32'(dif.out_valid), 32'd1);
        check_val("held_data", 32'(dif.out_data), 32'h2B);
        run_edges(1, 3);
        check_val("ovr_set", 32'(dif.overrun), 32'd1);
        check_val("held_data2", 32'(dif.out_data), 32'h2B);
        dif.out_ready = 1'b1;
        run_edges(1, 3);
        check_val("valid_after_xfer", 32'(dif.out_valid), 32'd0);
        check_val("ovr_sticky", 32'(dif.overrun), 32'd1);
        run_edges(127, 3);
        disable_run();
        check_val("ovr_idle", 32'(dif.overrun), 32'd1);
        check_val("sb_drain_ovr", 32'(sb.size()), 32'd0);

        // en dropped mid-window at edge 300, raised at edge 310
        enable_run();
        check_val("ovr_cleared", 32'(dif.overrun), 32'd0);
        run_edges(299, 2);
        dif.en = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check_val("gap_busy", 32'(dif.busy), 32'd0);
        check_val("gap_valid", 32'(dif.out_valid), 32'd0);
        enable_run();
        run_edges(383, 2);
        check_val("reen_no_early", 32'(dif.out_valid), 32'd0);
        run_edges(1, 2);
        check_val("reen_valid", 32'(dif.out_valid), 32'd1);
        check_val("reen_data", 32'(dif.out_data), 32'h25);
        run_edges(1, 2);
        disable_run();
        check_val("sb_drain_reen", 32'(sb.size()), 32'd0);

        // asynchronous reset while busy
        enable_run();
        run_edges(200, 2);
        check_val("busy_200", 32'(dif.busy), 32'd1);
        reset = 1'b1;
        dif.en = 1'b0;
        #1;
        check_val("arst_valid", 32'(dif.out_valid), 32'd0);
        check_val("arst_data", 32'(dif.out_data), 32'd0);
        check_val("arst_overrun", 32'(dif.overrun), 32'd0);
        check_val("arst_busy", 32'(dif.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (500) begin
            @(posedge clk); #1;
            if (dif.out_valid === 1'b1 || dif.busy === 1'b1) seen++;
        end
        check_val("idle_after_rst", 32'(seen), 32'd0);

        // small instance: L=8, SETTLE=0, alternating bits starting with 1
        dif8.en = 1'b1;
        @(posedge clk); #1;
        for (int e = 1; e <= 40; e++) begin
            dif8.bit_in = (e % 2) == 1;
            if (e % 8 == 0) sb8.push_back(4'd4);
            @(posedge clk); #1;
            if (e == 7) check_val("s8_no_valid_7", 32'(dif8.out_valid), 32'd0);
            if (e == 8) begin
                check_val("s8_valid_8", 32'(dif8.out_valid), 32'd1);
                check_val("s8_data_8", 32'(dif8.out_data), 32'd4);
            end
            if (e == 16) check_val("s8_data_16", 32'(dif8.out_data), 32'd4);
        end
        dif8.en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("sb8_drain", 32'(sb8.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dsm_decimator.md
# dsm_decimator

First-order (sinc1) decimator that consumes the 1-bit carry-out bitstream of the DSM accumulator and produces one multi-bit sample per window of 2^OSR_LOG2 clocks. Counts the ones in each window and presents the result on a valid/ready output port. Includes an enable-driven settle phase that discards start-up windows, and a sticky overrun flag. Sits directly downstream of the accumulator in the DSM core, in the same clock domain.

## Interface
- OSR_LOG2, 7: log2 of the oversampling ratio; window length L = 2^OSR_LOG2 clocks (128, matching the 7-bit accumulator).
- SETTLE, 2: number of complete windows discarded after each enable, range 0..15.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable, level-sensitive.
- bit_in  in  1  DSM bitstream (accumulator carry-out).
- out_ready  in  1  consumer ready.
- out_data  out  OSR_LOG2+1  ones count of the last completed window.
- out_valid  out  1  out_data holds an unconsumed sample.
- overrun  out  1  sticky; a completed window was dropped.
- busy  out  1  high in SETTLE or RUN.

## Operation
- Reset values: state IDLE; window counter, ones counter, settle counter, out_data, out_valid, overrun and busy all 0.
- FSM states and transitions:
  - IDLE → SETTLE on an edge that samples en=1. Going to RUN instead when SETTLE=0.
  - SETTLE → RUN on the edge that closes the SETTLE-th window.
  - SETTLE or RUN → IDLE on any edge that samples en=0. The partial window is discarded.
- Entering SETTLE (or RUN directly) clears the window counter, the ones counter and overrun.
- In SETTLE and RUN, bit_in is sampled on every edge.
  - The window counter runs 0..L-1 and wraps.
  - The ones counter adds bit_in.
  - The window closes on the edge where the window counter is L-1. The result includes that edge's bit_in.
  - The ones counter restarts from 0 for the next window, with no gap cycle.
- Result width is OSR_LOG2+1 bits. An all-ones window yields exactly L (0x80 at default).
- In SETTLE, closed windows only increment the settle counter; the output is untouched.
- In RUN, on window close:
  - If out_valid=0, or out_valid=1 with out_ready=1 on that edge: load out_data and hold out_valid=1.
  - If out_valid=1 with out_ready=0: the new result is dropped, out_data is unchanged and overrun is set to 1.
- Handshake: a transfer occurs on any edge with out_valid=1 and out_ready=1. out_valid falls on that edge unless a new result loads on the same edge.
- out_data is stable while out_valid=1 and not transferred.
- When en falls, a pending out_valid and out_data are retained until consumed.
- busy is a registered copy of (state != IDLE).

## Timing
- The enabling edge is edge 0. Bits are sampled on edges 1, 2, …
- The first RUN window closes on edge (SETTLE+1)·L. out_valid is high in the cycle after that edge: edge 384 at defaults.
- The next samples follow every L edges.
- Latency is 1 cycle from window close to out_valid/out_data, with no combinational path from bit_in to any output.
- out_ready may be held high permanently; every window is then delivered and overrun never sets.
- Reset asserted mid-operation forces all outputs to 0 immediately and asynchronously. After release, the block is in IDLE and needs a new en edge.

## Configuration
- DSM_DECIM_SAT_EN defined:
  - The ones counter saturates at L-1, so an all-ones window yields 0x7F at default.
  - The out_data MSB is always 0, and the result matches a 7-bit code.
- DSM_DECIM_SAT_EN undefined:
  - Full count range 0..L.
  - An all-ones window yields L (0x80).

## Test plan
- Defaults, out_ready=1, bit_in pattern with exactly 37 ones per 128-cycle window (phase-aligned to edge 1):
  - First out_valid after edge 384, out_data=0x25.
  - Further samples every 128 cycles, overrun=0.
- bit_in constant 1:
  - Without the macro, out_data=0x80.
  - With DSM_DECIM_SAT_EN, out_data=0x7F.
  - bit_in constant 0 gives 0x00 in both builds.
- out_ready=0 through two window closes in RUN:
  - The first result is held.
  - overrun=1 after the second close.
  - Raising out_ready transfers the first result.
  - overrun stays 1 until the next enable.
- en dropped at edge 300 (mid-window), raised again at edge 310:
  - Partial window discarded, overrun cleared.
  - First new sample follows (SETTLE+1)·128 edges after edge 310.
- Reset pulsed at edge 200 while busy=1:
  - All outputs 0 during reset.
  - After release, no out_valid until en is sampled high again.
- SETTLE=0, OSR_LOG2=3, alternating bit_in starting with 1:
  - out_data=4 every 8 cycles.
  - First out_valid after edge 8.
